// File: rtl/alu_dispatch.sv
// alu_dispatch: buffers ALU commands in a FIFO and issues them one at a time, holding each until alu_valid.
// Optional ALU_DISPATCH_PERF_EN adds perf_issued/perf_wait counters; otherwise both read 0.
module alu_dispatch #(
    parameter int N            = 32,
    parameter int WIDTH_OPCODE = 4,
    parameter int TAG_W        = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [WIDTH_OPCODE-1:0] cmd_opcode,
    input  logic [N-1:0]            cmd_a,
    input  logic [N-1:0]            cmd_b,
    input  logic [N-1:0]            cmd_imm,
    input  logic [TAG_W-1:0]        cmd_tag,
    output logic                    alu_enable,
    output logic [WIDTH_OPCODE-1:0] alu_opcode,
    output logic [N-1:0]            alu_dataA,
    output logic [N-1:0]            alu_dataB,
    output logic [N-1:0]            alu_data_imm,
    input  logic                    alu_valid,
    input  logic                    alu_zero,
    input  logic [N-1:0]            alu_data,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [N-1:0]            res_data,
    output logic                    res_zero,
    output logic                    res_err,
    output logic [TAG_W-1:0]        res_tag,
    output logic                    busy,
    output logic [31:0]             perf_issued,
    output logic [31:0]             perf_wait
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT);
    localparam int EW = WIDTH_OPCODE + 3 * N + TAG_W;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t state, state_nx;

    logic [EW-1:0]           mem [FIFO_DEPTH];
    logic [AW:0]             wr_ptr, rd_ptr;
    logic                    empty, full, push, pop, legal, tmo;
    logic [WIDTH_OPCODE-1:0] head_op;
    logic [N-1:0]            head_a, head_b, head_imm;
    logic [TAG_W-1:0]        head_tag;
    logic [TW-1:0]           tcnt;

    assign empty     = wr_ptr == rd_ptr;
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign cmd_ready = !full && !rst;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && !empty;
    assign {head_op, head_a, head_b, head_imm, head_tag} = mem[rd_ptr[AW-1:0]];
    assign legal = (head_op <= WIDTH_OPCODE'(6)) || (head_op == WIDTH_OPCODE'(9)) ||
                   (head_op == WIDTH_OPCODE'(11)) || (head_op == WIDTH_OPCODE'(14)) ||
                   (head_op == WIDTH_OPCODE'(15));
    assign tmo       = tcnt == TW'(TIMEOUT - 1);
    assign res_valid = state == RESP;
    assign busy      = (state != IDLE) || !empty;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (!empty) state_nx = legal ? ISSUE : RESP;
            ISSUE:   if (alu_valid || tmo) state_nx = RESP;
            RESP:    if (res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {cmd_opcode, cmd_a, cmd_b, cmd_imm, cmd_tag};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Illegal opcodes skip ISSUE and answer directly with an error result.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_enable   <= 1'b0;
            alu_opcode   <= '0;
            alu_dataA    <= '0;
            alu_dataB    <= '0;
            alu_data_imm <= '0;
            res_data     <= '0;
            res_zero     <= 1'b0;
            res_err      <= 1'b0;
            res_tag      <= '0;
            tcnt         <= '0;
        end else begin
            if (pop) begin
                alu_enable   <= legal;
                alu_opcode   <= head_op;
                alu_dataA    <= head_a;
                alu_dataB    <= head_b;
                alu_data_imm <= head_imm;
                res_tag      <= head_tag;
                res_err      <= !legal;
                res_data     <= '0;
                res_zero     <= 1'b0;
                tcnt         <= '0;
            end
            if (state == ISSUE) begin
                if (alu_valid) begin
                    alu_enable <= 1'b0;
                    res_data   <= alu_data;
                    res_zero   <= alu_zero;
                    res_err    <= 1'b0;
                end else if (tmo) begin
                    alu_enable <= 1'b0;
                    res_data   <= '0;
                    res_zero   <= 1'b0;
                    res_err    <= 1'b1;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end
        end
    end

`ifdef ALU_DISPATCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issued <= '0;
            perf_wait   <= '0;
        end else begin
            if (pop && legal)                   perf_issued <= perf_issued + 1'b1;
            if (state == ISSUE && !alu_valid)   perf_wait   <= perf_wait + 1'b1;
        end
    end
`else
    assign perf_issued = 32'd0;
    assign perf_wait   = 32'd0;
`endif
endmodule

// File: tb/tb_alu_dispatch.sv
// tb_alu_dispatch: directed table of single commands against a behavioural ALU, plus FIFO-fill and mid-op reset sequences.
module tb_alu_dispatch;
    logic        clk = 1'b0, rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [3:0]  cmd_opcode = '0, cmd_tag = '0;
    logic [31:0] cmd_a = '0, cmd_b = '0, cmd_imm = '0;
    logic        alu_enable, alu_valid, alu_zero;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_dataA, alu_dataB, alu_data_imm, alu_data;
    logic        res_valid, res_ready = 1'b1, res_zero, res_err, busy;
    logic [31:0] res_data, perf_issued, perf_wait;
    logic [3:0]  res_tag;

    int tests = 0, fails = 0;
    int delay = 0;
    bit stuck = 1'b0;
    logic [7:0] en_cnt;

    always #5 clk = ~clk;

    alu_dispatch #(.N(32), .WIDTH_OPCODE(4), .TAG_W(4), .FIFO_DEPTH(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_imm(cmd_imm), .cmd_tag(cmd_tag),
        .alu_enable(alu_enable), .alu_opcode(alu_opcode), .alu_dataA(alu_dataA), .alu_dataB(alu_dataB),
        .alu_data_imm(alu_data_imm), .alu_valid(alu_valid), .alu_zero(alu_zero), .alu_data(alu_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_zero(res_zero),
        .res_err(res_err), .res_tag(res_tag), .busy(busy), .perf_issued(perf_issued), .perf_wait(perf_wait)
    );

    // Behavioural ALU: valid after `delay` enabled cycles (0 = combinational), never when stuck.
    always_ff @(posedge clk) en_cnt <= alu_enable ? en_cnt + 8'd1 : 8'd0;
    assign alu_valid = alu_enable && !stuck && (en_cnt == 8'(delay));
    always_comb begin
        alu_data = alu_dataA ^ alu_dataB;
        case (alu_opcode)
            4'h0: alu_data = alu_dataA + alu_dataB;
            4'hF: alu_data = alu_dataA - alu_dataB;
            4'h4: alu_data = alu_dataA * alu_dataB;
            4'h5: alu_data = (alu_dataB == 0) ? 32'd0 : alu_dataA / alu_dataB;
            default: ;
        endcase
        alu_zero = alu_data == 32'd0;
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [3:0]  tag;
        int          dly;
        bit          stk;
        logic [31:0] exp_data;
        logic        exp_zero, exp_err;
        int          exp_lat, exp_en;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc, en;
        bit moved;
        logic [131:0] snap;
        delay = v.dly;
        stuck = v.stk;
        cmd_valid = 1'b1; cmd_opcode = v.op; cmd_a = v.a; cmd_b = v.b; cmd_imm = v.a + v.b; cmd_tag = v.tag;
        check($sformatf("v%0d ready", idx), {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc = 1; en = 0; moved = 1'b0; snap = '0;
        while (!res_valid && cyc < 40) begin
            if (alu_enable) begin
                if (en == 0) snap = {alu_opcode, alu_dataA, alu_dataB, alu_data_imm};
                else if (snap != {alu_opcode, alu_dataA, alu_dataB, alu_data_imm}) moved = 1'b1;
                en++;
            end
            @(negedge clk);
            cyc++;
        end
        check($sformatf("v%0d latency", idx), 32'(cyc), 32'(v.exp_lat));
        check($sformatf("v%0d enable_cycles", idx), 32'(en), 32'(v.exp_en));
        check($sformatf("v%0d operands_stable", idx), {31'd0, moved}, 32'd0);
        check($sformatf("v%0d data", idx), res_data, v.exp_data);
        check($sformatf("v%0d zero", idx), {31'd0, res_zero}, {31'd0, v.exp_zero});
        check($sformatf("v%0d err", idx), {31'd0, res_err}, {31'd0, v.exp_err});
        check($sformatf("v%0d tag", idx), {28'd0, res_tag}, {28'd0, v.tag});
        check($sformatf("v%0d enable_low_in_resp", idx), {31'd0, alu_enable}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n, got;
        vecs[0] = '{4'h0, 32'd5, 32'd7, 4'd3, 0, 1'b0, 32'd12, 1'b0, 1'b0, 3, 1};
        vecs[1] = '{4'hF, 32'd9, 32'd9, 4'd1, 0, 1'b0, 32'd0, 1'b1, 1'b0, 3, 1};
        vecs[2] = '{4'h4, 32'd6, 32'd7, 4'd2, 5, 1'b0, 32'd42, 1'b0, 1'b0, 8, 6};
        vecs[3] = '{4'h7, 32'd1, 32'd2, 4'd4, 0, 1'b0, 32'd0, 1'b0, 1'b1, 2, 0};
        vecs[4] = '{4'h5, 32'd100, 32'd7, 4'd5, 2, 1'b0, 32'd14, 1'b0, 1'b0, 5, 3};
        vecs[5] = '{4'h9, 32'hF0, 32'h0F, 4'd6, 0, 1'b0, 32'hFF, 1'b0, 1'b0, 3, 1};
        vecs[6] = '{4'hE, 32'd3, 32'd3, 4'd7, 0, 1'b0, 32'd0, 1'b1, 1'b0, 3, 1};
        vecs[7] = '{4'h0, 32'hFFFF_FFFF, 32'd1, 4'd8, 0, 1'b0, 32'd0, 1'b1, 1'b0, 3, 1};
        vecs[8] = '{4'h0, 32'd1, 32'd1, 4'd9, 0, 1'b1, 32'd0, 1'b0, 1'b1, 10, 8};
        vecs[9] = '{4'h8, 32'd4, 32'd4, 4'd10, 0, 1'b0, 32'd0, 1'b0, 1'b1, 2, 0};

        repeat (3) @(negedge clk);
        check("rst cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst alu_enable", {31'd0, alu_enable}, 32'd0);
        check("rst res_valid", {31'd0, res_valid}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst res_data", res_data, 32'd0);
        check("rst res_err", {31'd0, res_err}, 32'd0);
        check("rst perf_issued", perf_issued, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst cmd_ready", {31'd0, cmd_ready}, 32'd1);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

`ifdef ALU_DISPATCH_PERF_EN
        check("perf_issued", perf_issued, 32'd8);
        check("perf_wait", perf_wait, 32'd15);
`else
        check("perf_issued off", perf_issued, 32'd0);
        check("perf_wait off", perf_wait, 32'd0);
`endif

        // Fill the FIFO while the first result is held.
        delay = 0; stuck = 1'b0; res_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cmd_valid = 1'b1; cmd_opcode = 4'h0; cmd_a = 32'(k); cmd_b = 32'd10; cmd_imm = 32'd0; cmd_tag = 4'(k + 1);
            check($sformatf("fill ready%0d", k), {31'd0, cmd_ready}, 32'd1);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        check("fill full", {31'd0, cmd_ready}, 32'd0);
        check("fill busy", {31'd0, busy}, 32'd1);
        check("fill held tag", {28'd0, res_tag}, 32'd1);
        res_ready = 1'b1;
        got = 0; n = 0;
        while (got < 5 && n < 100) begin
            if (res_valid) begin
                check($sformatf("fill data%0d", got), res_data, 32'(got + 10));
                check($sformatf("fill tag%0d", got), {28'd0, res_tag}, 32'(got + 1));
                got++;
            end
            @(negedge clk);
            n++;
        end
        check("fill count", 32'(got), 32'd5);
        check("fill drained busy", {31'd0, busy}, 32'd0);

        // Reset while a divide is stuck in ISSUE with another command queued.
        stuck = 1'b1;
        cmd_valid = 1'b1; cmd_opcode = 4'h5; cmd_a = 32'd100; cmd_b = 32'd5; cmd_tag = 4'd11;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!alu_enable && n < 10) begin @(negedge clk); n++; end
        check("div issued", {31'd0, alu_enable}, 32'd1);
        cmd_valid = 1'b1; cmd_opcode = 4'h0; cmd_tag = 4'd12;
        @(negedge clk);
        cmd_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("midrst alu_enable", {31'd0, alu_enable}, 32'd0);
        check("midrst res_valid", {31'd0, res_valid}, 32'd0);
        check("midrst busy", {31'd0, busy}, 32'd0);
        check("midrst cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("midrst perf_issued", perf_issued, 32'd0);
        check("midrst perf_wait", perf_wait, 32'd0);
        rst = 1'b0; stuck = 1'b0;
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (res_valid || alu_enable || busy) n++;
        end
        check("midrst idle after", 32'(n), 32'd0);
        run_vec(vecs[0], 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
